// File: rtl/render_scheduler_pkg.sv
// Shared types for the render scheduler: FSM state encoding and object-table entry layout.
package render_scheduler_pkg;

  // Facet address/count width stored in each table entry; the top-level ADDR_WIDTH is expected
  // to match this, and values are cast at the boundary so a mismatch only truncates or extends.
  localparam int unsigned ObjAddrWidth = 12;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StScan  = 3'd1,
    StIssue = 3'd2,
    StWait  = 3'd3,
    StDone  = 3'd4
  } state_e;

  typedef struct packed {
    logic                    enable;
    logic [ObjAddrWidth-1:0] base;
    logic [ObjAddrWidth-1:0] count;
  } obj_entry_t;

  // An entry produces a fetch command only when enabled and it has at least one facet.
  function automatic logic entry_live(input obj_entry_t entry);
    return entry.enable && (entry.count != '0);
  endfunction

endpackage

// File: rtl/render_scheduler_if.sv
// Fetch-command bus between the render scheduler (master) and the vertex fetcher (slave).
interface render_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned IDX_WIDTH  = 2
);

  logic                  cmd_valid_out;
  logic                  cmd_ready_in;
  logic [ADDR_WIDTH-1:0] cmd_base_out;
  logic [ADDR_WIDTH-1:0] cmd_count_out;
  logic [IDX_WIDTH-1:0]  cmd_obj_out;
  logic                  obj_done_in;

  modport master (
    output cmd_valid_out,
    output cmd_base_out,
    output cmd_count_out,
    output cmd_obj_out,
    input  cmd_ready_in,
    input  obj_done_in
  );

  modport slave (
    input  cmd_valid_out,
    input  cmd_base_out,
    input  cmd_count_out,
    input  cmd_obj_out,
    output cmd_ready_in,
    output obj_done_in
  );

endinterface

// File: rtl/render_scheduler_obj_table.sv
// Object table: one write port from the config bus, one combinational read port for the scanner.
module render_scheduler_obj_table
  import render_scheduler_pkg::*;
#(
  parameter int unsigned NUM_OBJECTS = 4,
  parameter int unsigned IDX_WIDTH   = $clog2(NUM_OBJECTS)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 we_in,
  input  logic [IDX_WIDTH-1:0] wr_idx_in,
  input  obj_entry_t           wr_entry_in,
  input  logic [IDX_WIDTH-1:0] rd_idx_in,
  output obj_entry_t           rd_entry_out
);

  obj_entry_t entries_q [NUM_OBJECTS];

  // Table storage; reset clears every entry, writes to non-existent indices are dropped.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_OBJECTS; i++) begin
        entries_q[i] <= '0;
      end
    end else if (we_in && (32'(wr_idx_in) < NUM_OBJECTS)) begin
      entries_q[wr_idx_in] <= wr_entry_in;
    end
  end

  // Read returns the registered value, so a same-cycle write is not visible until the next cycle.
  always_comb begin
    rd_entry_out = '0;
    if (32'(rd_idx_in) < NUM_OBJECTS) begin
      rd_entry_out = entries_q[rd_idx_in];
    end
  end

endmodule

// File: rtl/render_scheduler.sv
// Render scheduler: walks the object table once per frame and issues one fetch command per
// live object, waiting for the fetcher to finish each object before moving on.
module render_scheduler
  import render_scheduler_pkg::*;
#(
  parameter int unsigned NUM_OBJECTS = 4,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned IDX_WIDTH   = $clog2(NUM_OBJECTS)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  frame_start_in,
  input  logic                  cfg_we_in,
  input  logic [IDX_WIDTH-1:0]  cfg_idx_in,
  input  logic [ADDR_WIDTH-1:0] cfg_base_in,
  input  logic [ADDR_WIDTH-1:0] cfg_count_in,
  input  logic                  cfg_enable_in,
  render_scheduler_if.master    cmd_if,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic [7:0]            overrun_count_out
);

  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_OBJECTS - 1);

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] cmd_base_q, cmd_base_d;
  logic [ADDR_WIDTH-1:0] cmd_count_q, cmd_count_d;
  logic [IDX_WIDTH-1:0]  cmd_obj_q, cmd_obj_d;
  logic [7:0]            overrun_q, overrun_d;
  obj_entry_t            wr_entry;
  obj_entry_t            rd_entry;

  assign wr_entry = '{
    enable: cfg_enable_in,
    base:   ObjAddrWidth'(cfg_base_in),
    count:  ObjAddrWidth'(cfg_count_in)
  };

  render_scheduler_obj_table #(
    .NUM_OBJECTS(NUM_OBJECTS),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_obj_table (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .we_in       (cfg_we_in),
    .wr_idx_in   (cfg_idx_in),
    .wr_entry_in (wr_entry),
    .rd_idx_in   (idx_q),
    .rd_entry_out(rd_entry)
  );

  // Next-state logic for the traversal FSM and the command snapshot registers.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cmd_base_d  = cmd_base_q;
    cmd_count_d = cmd_count_q;
    cmd_obj_d   = cmd_obj_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start_in) begin
          state_d = StScan;
          idx_d   = '0;
        end
      end
      StScan: begin
        if (entry_live(rd_entry)) begin
          // Snapshot the entry so later config writes cannot disturb an issued command.
          cmd_base_d  = ADDR_WIDTH'(rd_entry.base);
          cmd_count_d = ADDR_WIDTH'(rd_entry.count);
          cmd_obj_d   = idx_q;
          state_d     = StIssue;
        end else if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IDX_WIDTH'(1);
        end
      end
      StIssue: begin
        if (cmd_if.cmd_ready_in) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (cmd_if.obj_done_in) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IDX_WIDTH'(1);
            state_d = StScan;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Frame requests arriving while a traversal is in flight are dropped and counted.
  always_comb begin
    overrun_d = overrun_q;
    if (frame_start_in && (state_q != StIdle) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  // State registers; reset wins over any same-cycle frame request or config write.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cmd_base_q  <= '0;
      cmd_count_q <= '0;
      cmd_obj_q   <= '0;
      overrun_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cmd_base_q  <= cmd_base_d;
      cmd_count_q <= cmd_count_d;
      cmd_obj_q   <= cmd_obj_d;
      overrun_q   <= overrun_d;
    end
  end

  // Outputs decoded from registered state only.
  assign cmd_if.cmd_valid_out = (state_q == StIssue);
  assign cmd_if.cmd_base_out  = cmd_base_q;
  assign cmd_if.cmd_count_out = cmd_count_q;
  assign cmd_if.cmd_obj_out   = cmd_obj_q;
  assign busy_out             = (state_q != StIdle);
  assign frame_done_out       = (state_q == StDone);
  assign overrun_count_out    = overrun_q;

endmodule
